// File: rtl/alu_pkg.sv
// Shared constants and FSM encodings for the arithmetic blocks.
package alu_pkg;

  localparam int DEFAULT_N = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Step counter has one spare bit beyond the index range.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/seq_multiplier_if.sv
// Operand/result bundle for the sequential multiplier.
interface seq_multiplier_if #(
  parameter int N = alu_pkg::DEFAULT_N
) ();

  logic           start;
  logic [N-1:0]   A;
  logic [N-1:0]   B;
  logic           busy;
  logic           done;
  logic [2*N-1:0] P;

  modport master (
    output start, A, B,
    input  busy, done, P
  );

  modport slave (
    input  start, A, B,
    output busy, done, P
  );

endinterface

// File: rtl/seq_multiplier_adder.sv
// Structural ripple-carry adder; one full-adder cell per bit.
module Adder #(
  parameter int n = 32
) (
  input  logic [n-1:0] A,
  input  logic [n-1:0] B,
  input  logic         Cin,
  output logic [n-1:0] S,
  output logic         Cout
);

  logic [n:0] carry;

  assign carry[0] = Cin;

  generate
    for (genvar gi = 0; gi < n; gi++) begin : g_fa
      logic half_sum;
      assign half_sum     = A[gi] ^ B[gi];
      assign S[gi]        = half_sum ^ carry[gi];
      assign carry[gi+1]  = (A[gi] & B[gi]) | (carry[gi] & half_sum);
    end
  endgenerate

  assign Cout = carry[n];

endmodule

// File: rtl/seq_multiplier.sv
// Unsigned shift-add multiplier: one partial-product step per clock,
// N steps per operation, product held in P until the next start.
module seq_multiplier
  import alu_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic            clk,
  input  logic            rst_n,
  seq_multiplier_if.slave bus
);

  localparam int              CW   = cnt_width(N);
  localparam logic [CW-1:0]   LAST = CW'(N - 1);

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [N-1:0]     mcand_reg, mcand_next;
  logic [2*N-1:0]   p_reg, p_next;
  logic             busy_reg, done_reg;

  logic [N-1:0]     addend;
  logic [N-1:0]     sum;
  logic             carry;

  assign addend = p_reg[0] ? mcand_reg : '0;

  Adder #(.n(N)) u_adder (
    .A    (p_reg[2*N-1:N]),
    .B    (addend),
    .Cin  (1'b0),
    .S    (sum),
    .Cout (carry)
  );

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    mcand_next = mcand_reg;
    p_next     = p_reg;
    case (state_reg)
      ST_IDLE: begin
        if (bus.start) begin
          mcand_next = bus.A;
          p_next     = {{N{1'b0}}, bus.B};
          cnt_next   = '0;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        // Carry-out lands in the top bit, so the full 2N-bit product never overflows.
        p_next   = {carry, sum, p_reg[N-1:1]};
        cnt_next = cnt_reg + CW'(1);
        if (cnt_reg == LAST) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      mcand_reg <= '0;
      p_reg     <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      mcand_reg <= mcand_next;
      p_reg     <= p_next;
      // Status flags registered from the next state so they track the FSM glitch-free.
      busy_reg  <= (state_next == ST_RUN);
      done_reg  <= (state_next == ST_DONE);
    end
  end

  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
  assign bus.P    = p_reg;

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 Parameter: N, default 32, operand width in bits; legal range 2..64.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: start  input  1  request to begin a multiply; sampled on clk rising edge.
REQ-005 Port: A  input  N  multiplicand, unsigned; sampled with start.
REQ-006 Port: B  input  N  multiplier, unsigned; sampled with start.
REQ-007 Port: busy  output  1  high while an operation is in progress (RUN state).
REQ-008 Port: done  output  1  single-cycle pulse marking P valid for the latest operation.
REQ-009 Port: P  output  2N  product register, unsigned.

Function
REQ-010 The block SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-011 In IDLE with start=1 at edge E0, the block SHALL capture A into the multiplicand register, load P[N-1:0]=B and P[2N-1:N]=0, clear the iteration counter, and enter RUN.
REQ-012 In RUN, each edge SHALL perform one shift-add step: sum = P[2N-1:N] + (P[0] ? multiplicand : 0) with carry-in 0, then P <= {carry-out, sum, P[N-1:1]}.
REQ-013 The carry-out of each step SHALL be retained as P[2N-1]; no overflow is possible and none SHALL be flagged.
REQ-014 RUN SHALL last exactly N edges (E1..EN); the counter SHALL increment per step and RUN->DONE SHALL occur at EN.
REQ-015 done SHALL be 1 for exactly the one cycle the FSM is in DONE (between EN and EN+1); DONE->IDLE SHALL occur unconditionally at EN+1.
REQ-016 busy SHALL equal 1 exactly when the FSM is in RUN.
REQ-017 P SHALL hold the final product from EN until the next accepted start; P is not meaningful during RUN.
REQ-018 start SHALL be ignored in RUN and DONE; A and B changes outside the capturing edge SHALL have no effect.
REQ-019 Earliest next start acceptance: edge EN+1 is not a capture edge; a start held high through DONE SHALL be captured at EN+2 (first edge in IDLE).
REQ-020 Operand zero cases (A=0 or B=0) SHALL still take the full N steps and yield P=0.

Reset
REQ-021 rst_n=0 SHALL asynchronously force FSM=IDLE, counter=0, multiplicand=0, P=0, busy=0, done=0.
REQ-022 Reset asserted during RUN or DONE SHALL abort the operation with no done pulse; after release the block SHALL accept a new start normally.
REQ-023 Outputs SHALL be glitch-free registered values; no output SHALL depend combinationally on start, A or B.

Structure
REQ-024 FSM state encodings and the default width constant SHALL live in the shared package alu_pkg.
REQ-025 The per-step addition SHALL use one instance of the team's existing structural ripple-carry Adder (parameter n=N, Cin tied 0, Cout feeding P[2N-1]); no behavioural "+" SHALL be used for the datapath sum.
REQ-026 Counter width SHALL be clog2(N)+1 bits; all datapath logic apart from the Adder SHALL reside in seq_multiplier.

Verification
REQ-027 N=32, A=3, B=5, start pulse at E0 -> busy high E0..EN, done pulse after E32, P=0x0000_0000_0000_000F.
REQ-028 A=B=0xFFFF_FFFF -> P=0xFFFF_FFFE_0000_0001 with done after E32 (carry path exercised).
REQ-029 A=0x1234_5678, B=0 and A=0, B=0xDEAD_BEEF -> P=0 in both, full 32-step latency.
REQ-030 start re-asserted with A=7, B=7 during RUN of 6*7 -> ignored; P=42, exactly one done pulse.
REQ-031 rst_n pulsed low at E10 of a run -> all outputs 0 immediately, no done; subsequent 9*9 run -> P=81.
REQ-032 start held high continuously, operands 2*3 then 4*5 -> captures at E0 and E34, P=6 then P=20, two done pulses.
